// File: rtl/level_debouncer.sv
// Synchronizing level debouncer with mismatch-run timer.
// Optional glitch counter: define LEVEL_DEBOUNCER_GLITCH_COUNT_EN.
module level_debouncer #(
  parameter int   SYNC_DEPTH    = 2,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock_enable,
  input  logic       level_in,
  output logic       level_out,
`ifdef LEVEL_DEBOUNCER_GLITCH_COUNT_EN
  output logic       settling,
  output logic [7:0] glitch_count
`else
  output logic       settling
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {
    STABLE,
    SETTLING
  } state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_level;
  logic                  mismatch;
  logic                  last;

  assign sync_level = sync_q[SYNC_DEPTH-1];
  assign mismatch   = sync_level != level_out;
  // True when this mismatching edge completes the run.
  assign last       = count == CW'(STABLE_CYCLES - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_DEPTH{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], level_in};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= STABLE;
      count     <= '0;
      level_out <= RESET_LEVEL;
      settling  <= 1'b0;
`ifdef LEVEL_DEBOUNCER_GLITCH_COUNT_EN
      glitch_count <= 8'd0;
`endif
    end else if (clock_enable) begin
      unique case (state)
        STABLE: begin
          if (mismatch) begin
            if (last) begin
              level_out <= ~level_out;
            end else begin
              state    <= SETTLING;
              count    <= CW'(1);
              settling <= 1'b1;
            end
          end
        end
        SETTLING: begin
          if (mismatch) begin
            if (last) begin
              level_out <= ~level_out;
              state     <= STABLE;
              count     <= '0;
              settling  <= 1'b0;
            end else begin
              count <= count + CW'(1);
            end
          end else begin
            state    <= STABLE;
            count    <= '0;
            settling <= 1'b0;
`ifdef LEVEL_DEBOUNCER_GLITCH_COUNT_EN
            if (glitch_count != 8'hFF) begin
              glitch_count <= glitch_count + 8'd1;
            end
`endif
          end
        end
        default: begin
          state    <= STABLE;
          count    <= '0;
          settling <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_debouncer.sv
// Self-checking bench for level_debouncer against a run-length model.
// Honours LEVEL_DEBOUNCER_GLITCH_COUNT_EN when defined.
module tb_level_debouncer;

  localparam int   SD = 2;
  localparam int   SC = 4;
  localparam logic RL = 1'b0;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic clock_enable = 1'b1;
  logic level_in = 1'b0;
  logic level_out;
  logic settling;
`ifdef LEVEL_DEBOUNCER_GLITCH_COUNT_EN
  logic [7:0] glitch_count;
`endif

  int checks = 0;
  int errors = 0;

  level_debouncer #(
    .SYNC_DEPTH(SD),
    .STABLE_CYCLES(SC),
    .RESET_LEVEL(RL)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .clock_enable(clock_enable),
    .level_in(level_in),
    .level_out(level_out),
`ifdef LEVEL_DEBOUNCER_GLITCH_COUNT_EN
    .settling(settling),
    .glitch_count(glitch_count)
`else
    .settling(settling)
`endif
  );

  always #5 clock = ~clock;

  // Model: delay line of raw samples plus length of the current mismatch run.
  bit m_pipe[$];
  bit m_out;
  int m_run;
  int m_glitch;

  function automatic void model_reset();
    m_pipe.delete();
    for (int i = 0; i < SD; i++) m_pipe.push_back(RL);
    m_out = RL;
    m_run = 0;
    m_glitch = 0;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      bit s;
      s = m_pipe[SD-1];
      m_pipe.push_front(level_in);
      void'(m_pipe.pop_back());
      if (clock_enable) begin
        if (s != m_out) begin
          m_run++;
          if (m_run == SC) begin
            m_out = ~m_out;
            m_run = 0;
          end
        end else begin
          if (m_run > 0 && m_glitch < 255) m_glitch++;
          m_run = 0;
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (reset_n) begin
      check("model_level_out", int'(level_out), int'(m_out));
      check("model_settling", int'(settling), int'(m_run > 0));
`ifdef LEVEL_DEBOUNCER_GLITCH_COUNT_EN
      check("model_glitch", int'(glitch_count), m_glitch);
`endif
    end
  end

  task automatic edge_wait();
    @(posedge clock);
    #1;
  endtask

  task automatic settle_low(input int n);
    @(negedge clock);
    level_in = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_level_out", int'(level_out), int'(RL));
    check("rst_settling", int'(settling), 0);
`ifdef LEVEL_DEBOUNCER_GLITCH_COUNT_EN
    check("rst_glitch", int'(glitch_count), 0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check("por_level_out", int'(level_out), 0);
    check("por_settling", int'(settling), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Clean 0->1 step: rises on edge 6, settling after edges 3..5.
    level_in = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      edge_wait();
      check($sformatf("step_out_e%0d", e), int'(level_out), int'(e >= 6));
      check($sformatf("step_set_e%0d", e), int'(settling),
            int'(e >= 3 && e <= 5));
    end
    settle_low(10);

    // Three-cycle glitch aborts.
    level_in = 1'b1;
    repeat (3) @(negedge clock);
    level_in = 1'b0;
    repeat (7) edge_wait();
    check("glitch_out", int'(level_out), 0);
    check("glitch_set", int'(settling), 0);
`ifdef LEVEL_DEBOUNCER_GLITCH_COUNT_EN
    check("glitch_cnt", int'(glitch_count), 1);
`endif

    // Enable stall with counter at 2.
    @(negedge clock);
    level_in = 1'b1;
    repeat (4) @(negedge clock);
    clock_enable = 1'b0;
    repeat (10) @(negedge clock);
    check("stall_out", int'(level_out), 0);
    check("stall_set", int'(settling), 1);
    clock_enable = 1'b1;
    edge_wait();
    check("resume1_out", int'(level_out), 0);
    edge_wait();
    check("resume2_out", int'(level_out), 1);
    settle_low(10);

    // Async reset mid-settle, then held-high input.
    @(negedge clock);
    level_in = 1'b1;
    repeat (3) @(negedge clock);
    pulse_reset();
    for (int e = 1; e <= 6; e++) begin
      edge_wait();
      check($sformatf("rel_out_e%0d", e), int'(level_out), int'(e >= 6));
    end
    settle_low(10);

    // 300 two-cycle glitches saturate the counter.
    for (int g = 0; g < 300; g++) begin
      @(negedge clock);
      level_in = 1'b1;
      repeat (2) @(negedge clock);
      level_in = 1'b0;
      repeat (3) @(negedge clock);
    end
    check("sat_out", int'(level_out), 0);
`ifdef LEVEL_DEBOUNCER_GLITCH_COUNT_EN
    check("sat_cnt", int'(glitch_count), 255);
`endif

    // Random soak against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if ($urandom_range(7) == 0) level_in = ~level_in;
      clock_enable = ($urandom_range(7) != 0);
      if ($urandom_range(599) == 0) pulse_reset();
    end

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
